// File: rtl/apb_timer_slave_if.sv
// APB request/response bundle between a master and the apb_timer_slave completer.
interface apb_timer_slave_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_timer_slave.sv
// APB leaf peripheral: down-counting timer with external gate/clock input and maskable interrupt.
// Optional: define APB_TIMER_SLVERR_EN to flag unmapped accesses and REV writes with pslverr.
module apb_timer_slave #(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] RELOAD_RST = 32'd0
) (
    input  logic             pclk,
    input  logic             preset,
    apb_timer_slave_if.slave apb,
    input  logic [31:0]      ecorevnum,
    input  logic             extin,
    output logic             timerint
);
    localparam logic [9:0] IDX_CTRL    = 10'd0;
    localparam logic [9:0] IDX_VALUE   = 10'd1;
    localparam logic [9:0] IDX_RELOAD  = 10'd2;
    localparam logic [9:0] IDX_INTSTAT = 10'd3;
    localparam logic [9:0] IDX_REV     = 10'd4;

    logic [3:0]       ctrl_q, ctrl_d;
    logic [CNT_W-1:0] value_q, value_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             intstat_q, intstat_d;
    logic             timerint_q, timerint_d;
    // [0] first sync stage, [1] extin_s, [2] delayed copy for edge detect
    logic [2:0]       sync_q, sync_d;

    logic [9:0]  idx_s;
    logic        wr_s, wr_value_s, clr_s, set_s;
    logic        extin_s, extin_d_s, rise_s, tick_s;
    logic        mapped_s, slverr_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign idx_s      = apb.paddr[11:2];
    assign wr_s       = apb.psel & apb.penable & apb.pwrite;
    assign wr_value_s = wr_s & (idx_s == IDX_VALUE);
    assign clr_s      = wr_s & (idx_s == IDX_INTSTAT) & apb.pwdata[0];
    assign mapped_s   = (idx_s <= IDX_REV);
    assign unused_s   = ^{apb.paddr[31:12], apb.paddr[1:0]};

    assign extin_s   = sync_q[1];
    assign extin_d_s = sync_q[2];
    assign rise_s    = extin_s & ~extin_d_s;
    assign tick_s    = ctrl_q[0] & (~ctrl_q[1] | extin_s) & (~ctrl_q[2] | rise_s);
    // A VALUE write discards a coincident tick, including its interrupt
    assign set_s     = tick_s & ~wr_value_s & (value_q == {CNT_W{1'b0}});

    // Next-state logic for registers, counter, interrupt and synchroniser
    always_comb begin
        sync_d     = {sync_q[1:0], extin};
        ctrl_d     = ctrl_q;
        value_d    = value_q;
        reload_d   = reload_q;
        intstat_d  = intstat_q;
        timerint_d = intstat_q & ctrl_q[3];

        if (wr_value_s) begin
            value_d = apb.pwdata[CNT_W-1:0];
        end else if (tick_s) begin
            if (value_q == {CNT_W{1'b0}}) begin
                value_d = reload_q;
            end else begin
                value_d = value_q - CNT_W'(1'b1);
            end
        end else begin
            value_d = value_q;
        end

        if (set_s) begin
            intstat_d = 1'b1;
        end else if (clr_s) begin
            intstat_d = 1'b0;
        end else begin
            intstat_d = intstat_q;
        end

        if (wr_s && (idx_s == IDX_CTRL)) begin
            ctrl_d = apb.pwdata[3:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        if (wr_s && (idx_s == IDX_RELOAD)) begin
            reload_d = apb.pwdata[CNT_W-1:0];
        end else begin
            reload_d = reload_q;
        end
    end

    // Read data mux, zero outside a read
    always_comb begin
        rdata_s = 32'd0;
        if (apb.psel && !apb.pwrite) begin
            case (idx_s)
                IDX_CTRL:    rdata_s = {28'd0, ctrl_q};
                IDX_VALUE:   rdata_s[CNT_W-1:0] = value_q;
                IDX_RELOAD:  rdata_s[CNT_W-1:0] = reload_q;
                IDX_INTSTAT: rdata_s = {31'd0, intstat_q};
                IDX_REV:     rdata_s = ecorevnum;
                default:     rdata_s = 32'd0;
            endcase
        end else begin
            rdata_s = 32'd0;
        end
    end

`ifdef APB_TIMER_SLVERR_EN
    assign slverr_s = apb.psel & apb.penable &
                      (~mapped_s | (apb.pwrite & (idx_s == IDX_REV)));
`else
    assign slverr_s = 1'b0 & mapped_s;
`endif

    // State registers
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ctrl_q     <= 4'd0;
            value_q    <= RELOAD_RST[CNT_W-1:0];
            reload_q   <= RELOAD_RST[CNT_W-1:0];
            intstat_q  <= 1'b0;
            timerint_q <= 1'b0;
            sync_q     <= 3'd0;
        end else begin
            ctrl_q     <= ctrl_d;
            value_q    <= value_d;
            reload_q   <= reload_d;
            intstat_q  <= intstat_d;
            timerint_q <= timerint_d;
            sync_q     <= sync_d;
        end
    end

    assign apb.prdata  = rdata_s;
    assign apb.pready  = 1'b1;
    assign apb.pslverr = slverr_s;
    assign timerint    = timerint_q;
endmodule
